// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: steps the convolution MAC datapath through one run.
// Walks coefficient/sample addresses tap by tap (sample buffer is circular),
// pulses mac_clear then mac_en, waits out the MAC latency and pulses
// conv_complete. Optional build macro: CONV_STALL_EN adds a stall input that
// freezes the run in RUN/DRAIN.
module conv_mac_sequencer #(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned MAC_LAT = 2
) (
   input  logic              clk,
   input  logic              n_rst,
`ifdef CONV_STALL_EN
   input  logic              stall,
`endif
   input  logic              start_conv,
   input  logic [ADDR_W:0]   num_taps,
   input  logic [ADDR_W-1:0] sample_base,
   output logic [ADDR_W-1:0] coeff_addr,
   output logic [ADDR_W-1:0] sample_addr,
   output logic              mac_clear,
   output logic              mac_en,
   output logic              conv_complete,
   output logic              busy
);

   localparam int unsigned MAX_TAPS = 2 ** ADDR_W;
   localparam int unsigned DRAIN_W  = (MAC_LAT > 1) ? $clog2(MAC_LAT + 1) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST =
      (MAC_LAT > 0) ? DRAIN_W'(MAC_LAT - 1) : '0;
   localparam logic [ADDR_W:0] TAPS_MAX = (ADDR_W + 1)'(MAX_TAPS);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StRun,
      StDrain,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W:0]     taps_q, taps_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W:0]     tap_cnt_q, tap_cnt_d;
   logic [DRAIN_W-1:0]  drain_q, drain_d;
   logic [ADDR_W-1:0]   coeff_q, coeff_d;
   logic [ADDR_W-1:0]   sample_q, sample_d;
   logic                hold;
   logic                last_tap;

`ifdef CONV_STALL_EN
   assign hold = stall;
`else
   assign hold = 1'b0;
`endif

   assign last_tap = ((tap_cnt_q + (ADDR_W + 1)'(1)) == taps_q);

   // State and datapath registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= StIdle;
         taps_q    <= '0;
         base_q    <= '0;
         tap_cnt_q <= '0;
         drain_q   <= '0;
         coeff_q   <= '0;
         sample_q  <= '0;
      end else begin
         state_q   <= state_d;
         taps_q    <= taps_d;
         base_q    <= base_d;
         tap_cnt_q <= tap_cnt_d;
         drain_q   <= drain_d;
         coeff_q   <= coeff_d;
         sample_q  <= sample_d;
      end
   end

   // Next-state and counter/address update
   always_comb begin
      state_d   = state_q;
      taps_d    = taps_q;
      base_d    = base_q;
      tap_cnt_d = tap_cnt_q;
      drain_d   = drain_q;
      coeff_d   = coeff_q;
      sample_d  = sample_q;

      unique case (state_q)
         StIdle: begin
            if (start_conv) begin
               taps_d  = (num_taps > TAPS_MAX) ? TAPS_MAX : num_taps;
               base_d  = sample_base;
               state_d = StClear;
            end
         end
         StClear: begin
            tap_cnt_d = '0;
            drain_d   = '0;
            state_d   = (taps_q == '0) ? StDone : StRun;
         end
         StRun: begin
            if (!hold) begin
               if (last_tap) begin
                  drain_d = '0;
                  state_d = (MAC_LAT == 0) ? StDone : StDrain;
               end else begin
                  tap_cnt_d = tap_cnt_q + (ADDR_W + 1)'(1);
               end
            end
         end
         StDrain: begin
            if (!hold) begin
               if (drain_q == DRAIN_LAST) begin
                  state_d = StDone;
               end else begin
                  drain_d = drain_q + DRAIN_W'(1);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Address registers track the tap that will be presented next cycle,
      // and otherwise keep their last value.
      if (state_d == StRun) begin
         coeff_d  = tap_cnt_d[ADDR_W-1:0];
         sample_d = base_d - tap_cnt_d[ADDR_W-1:0];
      end
   end

   // Outputs decoded from registered state
   always_comb begin
      coeff_addr    = coeff_q;
      sample_addr   = sample_q;
      mac_clear     = (state_q == StClear);
      mac_en        = (state_q == StRun) && !hold;
      conv_complete = (state_q == StDone);
      busy          = (state_q != StIdle);
   end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Scoreboard bench for conv_mac_sequencer (ADDR_W=4, MAC_LAT=2).
// Stimulus pushes expected clear/tap/done events (tagged with the clock edge
// after which they must appear); a negedge monitor pops and compares.
module tb_conv_mac_sequencer;

   localparam int unsigned AW  = 4;
   localparam int unsigned LAT = 2;

   typedef struct {
      int unsigned e;
      logic [3:0]  c;
      logic [3:0]  s;
   } ev_t;

   logic           clk;
   logic           n_rst;
   logic           start_conv;
   logic [AW:0]    num_taps;
   logic [AW-1:0]  sample_base;
   logic [AW-1:0]  coeff_addr;
   logic [AW-1:0]  sample_addr;
   logic           mac_clear;
   logic           mac_en;
   logic           conv_complete;
   logic           busy;
`ifdef CONV_STALL_EN
   logic           stall;
`endif

   ev_t          tap_q[$];
   int unsigned  clr_q[$];
   int unsigned  done_q[$];
   int           checks;
   int           failures;
   int unsigned  edge_n;

   conv_mac_sequencer #(
      .ADDR_W  (AW),
      .MAC_LAT (LAT)
   ) dut (
      .clk           (clk),
      .n_rst         (n_rst),
`ifdef CONV_STALL_EN
      .stall         (stall),
`endif
      .start_conv    (start_conv),
      .num_taps      (num_taps),
      .sample_base   (sample_base),
      .coeff_addr    (coeff_addr),
      .sample_addr   (sample_addr),
      .mac_clear     (mac_clear),
      .mac_en        (mac_en),
      .conv_complete (conv_complete),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d (edge %0d)", name, got, exp, edge_n);
      end
   endtask

   // Monitor: every clear/tap/done the DUT presents must match the queue head
   always @(negedge clk) begin
      ev_t ev;
      if (mac_clear) begin
         check("clear_busy", 32'(busy), 1);
         check("clear_excl_en", 32'(mac_en), 0);
         if (clr_q.size() == 0) check("clear_unexpected", 32'(mac_clear), 0);
         else check("clear_edge", edge_n, clr_q.pop_front());
      end
      if (mac_en) begin
         check("tap_busy", 32'(busy), 1);
         if (tap_q.size() == 0) begin
            check("tap_unexpected", 32'(mac_en), 0);
         end else begin
            ev = tap_q.pop_front();
            check("tap_edge", edge_n, ev.e);
            check("tap_coeff", 32'(coeff_addr), 32'(ev.c));
            check("tap_sample", 32'(sample_addr), 32'(ev.s));
         end
      end
      if (conv_complete) begin
         check("done_busy", 32'(busy), 1);
         if (done_q.size() == 0) check("done_unexpected", 32'(conv_complete), 0);
         else check("done_edge", edge_n, done_q.pop_front());
      end
   end

   // Start sampled at edge s0: clear after s0, tap k after s0+1+k (+stall
   // cycles for k>=1), done after s0+N+LAT+1 (+stall), or after s0+1 when N==0.
   task automatic push_exp(input int unsigned n, input logic [3:0] base,
                           input int unsigned s0, input int unsigned stl);
      int unsigned eff;
      eff = (n > 16) ? 16 : n;
      clr_q.push_back(s0);
      for (int k = 0; k < int'(eff); k++) begin
         ev_t ev;
         ev.e = s0 + 1 + k + ((k >= 1) ? stl : 0);
         ev.c = 4'(k);
         ev.s = base - 4'(k);
         tap_q.push_back(ev);
      end
      if (eff > 0) done_q.push_back(s0 + eff + LAT + 1 + stl);
      else done_q.push_back(s0 + 1);
   endtask

   // Called just after a negedge; returns #1 after the sampling edge
   task automatic drive_start(input int unsigned n, input logic [3:0] base);
      start_conv  = 1'b1;
      num_taps    = 5'(n);
      sample_base = base;
      @(posedge clk);
      #1;
      start_conv  = 1'b0;
      // Changes after capture must not affect the run
      num_taps    = 5'd1;
      sample_base = 4'hA;
   endtask

   task automatic issue(input int unsigned n, input logic [3:0] base);
      push_exp(n, base, edge_n + 1, 0);
      drive_start(n, base);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done_q.size() != 0 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("done_timeout", done_q.size(), 0);
   endtask

   task automatic finish_run(input int unsigned n, input logic [3:0] base);
      int unsigned eff;
      eff = (n > 16) ? 16 : n;
      wait_done();
      @(negedge clk);
      #1;
      check("idle_busy", 32'(busy), 0);
      check("idle_en", 32'(mac_en), 0);
      if (eff > 0) begin
         check("hold_coeff", 32'(coeff_addr), eff - 1);
         check("hold_sample", 32'(sample_addr), 32'(4'(base - 4'(eff - 1))));
      end
   endtask

   task automatic check_all_zero(input string name);
      check(name, {coeff_addr, sample_addr, mac_clear, mac_en, conv_complete, busy}, 0);
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      n_rst       = 1'b1;
      start_conv  = 1'b0;
      num_taps    = '0;
      sample_base = '0;
`ifdef CONV_STALL_EN
      stall       = 1'b0;
`endif

      // Reset asserted mid-cycle, held over two clocks, then released
      #2 n_rst = 1'b0;
      #1 check_all_zero("reset_immediate");
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 check_all_zero("reset_held");
      n_rst = 1'b1;
      @(negedge clk);
      #1 check("reset_release_busy", 32'(busy), 0);

      // Normal run: 4 taps from base 2, sample addresses wrap 2,1,0,15
      issue(4, 4'd2);
      finish_run(4, 4'd2);

      // Mid-cycle reset while idle clears the held addresses at once
      #2 n_rst = 1'b0;
      #1 check_all_zero("reset_idle_addr");
      @(negedge clk);
      #1 n_rst = 1'b1;

      // Zero taps, then clamped 20 -> 16 taps
      issue(0, 4'd7);
      finish_run(0, 4'd7);
      issue(20, 4'd9);
      finish_run(20, 4'd9);

      // Re-pulse start during RUN and during DONE: both ignored
      issue(4, 4'd2);
      repeat (2) begin
         @(negedge clk);
         #1;
      end
      start_conv = 1'b1;
      num_taps   = 5'd3;
      @(posedge clk);
      #1 start_conv = 1'b0;
      wait_done();
      start_conv = 1'b1;
      @(posedge clk);
      #1 start_conv = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1 check("ignored_start_busy", 32'(busy), 0);
      end
      issue(3, 4'd0);
      finish_run(3, 4'd0);

      // Reset during RUN at tap 2 abandons the run
      issue(4, 4'd5);
      for (int i = 0; i < 20 && !(mac_en && coeff_addr == 4'd2); i++) begin
         @(negedge clk);
         #1;
      end
      check("reach_tap2", 32'(coeff_addr), 2);
      n_rst = 1'b0;
      tap_q.delete();
      clr_q.delete();
      done_q.delete();
      #1 check_all_zero("reset_run_immediate");
      repeat (2) @(negedge clk);
      #1 n_rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         #1 check("after_reset_idle", 32'(busy), 0);
      end
      issue(3, 4'd4);
      finish_run(3, 4'd4);

`ifdef CONV_STALL_EN
      // Stall three cycles at tap 1: done slips by exactly three cycles
      push_exp(4, 4'd2, edge_n + 1, 3);
      drive_start(4, 4'd2);
      repeat (2) @(posedge clk);
      #1 stall = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stall_en_low", 32'(mac_en), 0);
         check("stall_coeff", 32'(coeff_addr), 1);
         check("stall_sample", 32'(sample_addr), 1);
         @(posedge clk);
      end
      #1 stall = 1'b0;
      finish_run(4, 4'd2);
`endif

      repeat (3) @(negedge clk);
      check("leftover_events", tap_q.size() + clr_q.size() + done_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
